// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address mux, write-first bypass, zero-register override.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
  input  logic                                 we,
  input  logic [ADDR_W-1:0]                    wa,
  input  logic [DATA_W-1:0]                    wd,
  output logic [DATA_W-1:0]                    data
);

  logic [DATA_W-1:0] next_data;

  always_comb begin
    next_data = regs[addr];
    if (we && (wa == addr)) begin
      next_data = wd;
    end
    // Zero register wins over bypass so r0 can never leak write data.
    if ((ZERO_REG != 0) && (addr == '0)) begin
      next_data = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (en) begin
      data <= next_data;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with bypass, optional zero
// register and a sequenced bulk-clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  clr_state_t                   state;
  logic [ADDR_W-1:0]            cnt;

  logic              we_eff;
  logic [ADDR_W-1:0] wa_eff;
  logic [DATA_W-1:0] wd_eff;

  // External writes only land while idle; the clear engine owns the port otherwise.
  always_comb begin
    we_eff = 1'b0;
    wa_eff = '0;
    wd_eff = '0;
    case (state)
      IDLE: begin
        we_eff = wr_en;
        wa_eff = wr_addr;
        wd_eff = wr_data;
      end
      CLEAR: begin
        we_eff = 1'b1;
        wa_eff = cnt;
      end
      default: ;
    endcase
    if ((ZERO_REG != 0) && (wa_eff == '0)) begin
      we_eff = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (we_eff) begin
      mem[wa_eff] <= wd_eff;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clr_done <= 1'b0;
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state    <= DONE;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clock(clock),
      .reset(reset),
      .en   (rd_en[p]),
      .addr (rd_addr[p*ADDR_W +: ADDR_W]),
      .regs (mem),
      .we   (we_eff),
      .wa   (wa_eff),
      .wd   (wd_eff),
      .data (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table plus clear/reset sequences.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  rd_en;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic        clr_busy, clr_done;

  logic [1:0]  nz_en;
  logic [9:0]  nz_addr;
  logic [63:0] nz_data;
  logic        nz_busy, nz_done;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)) dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
    .clock(clock), .reset(reset), .rd_en(nz_en), .rd_addr(nz_addr),
    .rd_data(nz_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(nz_busy), .clr_done(nz_done)
  );

  typedef struct {
    logic             we;
    logic [4:0]       wa;
    logic [31:0]      wd;
    logic [3:0]       en;
    logic [3:0][4:0]  a;
    logic [3:0][31:0] e;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [3:0] en,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.en = en;
    v.a = {a3, a2, a1, a0};
    v.e = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; rd_en = '0; nz_en = '0;
  endtask

  vec_t vecs[12];

  initial begin
    int busy_cnt, done_cnt, done_at;

    vecs[0]  = mk(0, 0, 32'h0,        4'b1111, 0, 0, 0, 0,   32'h0, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mk(1, 5, 32'hDEADBEEF, 4'b0001, 5, 0, 0, 0,   32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,        4'b1111, 5, 5, 0, 1,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0);
    vecs[3]  = mk(1, 0, 32'h12345678, 4'b1111, 0, 0, 0, 0,   32'h0, 32'h0, 32'h0, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0,        4'b1111, 0, 0, 0, 0,   32'h0, 32'h0, 32'h0, 32'h0);
    vecs[5]  = mk(1, 7, 32'h55AA55AA, 4'b1111, 5, 7, 5, 7,   32'hDEADBEEF, 32'h55AA55AA, 32'hDEADBEEF, 32'h55AA55AA);
    vecs[6]  = mk(1, 9, 32'h11111111, 4'b1111, 9, 9, 9, 0,   32'h11111111, 32'h11111111, 32'h11111111, 32'h0);
    vecs[7]  = mk(0, 0, 32'h0,        4'b0000, 7, 7, 7, 7,   32'h11111111, 32'h11111111, 32'h11111111, 32'h0);
    vecs[8]  = mk(0, 0, 32'h0,        4'b1010, 7, 7, 7, 7,   32'h11111111, 32'h55AA55AA, 32'h11111111, 32'h55AA55AA);
    vecs[9]  = mk(1, 31, 32'hCAFEF00D, 4'b1111, 31, 30, 31, 5, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF);
    vecs[10] = mk(1, 5, 32'h0BADF00D, 4'b0001, 5, 5, 5, 5,   32'h0BADF00D, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF);
    vecs[11] = mk(0, 0, 32'h0,        4'b1111, 5, 9, 7, 31,  32'h0BADF00D, 32'h11111111, 32'h55AA55AA, 32'hCAFEF00D);

    idle_inputs();
    rd_addr = '0; nz_addr = '0;
    reset = 1'b1;
    #12 reset = 1'b0;
    step();
    chk("reset.busy", {31'd0, clr_busy}, 32'd0);
    chk("reset.done", {31'd0, clr_done}, 32'd0);
    for (int p = 0; p < 4; p++) chk($sformatf("reset.p%0d", p), rd_data[p*32 +: 32], 32'h0);

    for (int a = 0; a < 32; a++) begin
      rd_en = 4'b1111;
      rd_addr = {4{5'(a)}};
      step();
      for (int p = 0; p < 4; p++) chk($sformatf("rst_rd.a%0d.p%0d", a, p), rd_data[p*32 +: 32], 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      rd_en = vecs[i].en; rd_addr = vecs[i].a;
      step();
      for (int p = 0; p < 4; p++)
        chk($sformatf("vec%0d.p%0d", i, p), rd_data[p*32 +: 32], vecs[i].e[p]);
    end
    idle_inputs();

    // Without a zero register, r0 keeps the 0x12345678 written by vector 3.
    nz_en = 2'b11; nz_addr = '0;
    step();
    chk("nz.r0.p0", nz_data[31:0], 32'h12345678);
    chk("nz.r0.p1", nz_data[63:32], 32'h12345678);
    nz_en = '0;

    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 4'b0011; rd_addr = {5'd0, 5'd0, 5'd1, 5'd31};
    step();
    chk("fill.r31", rd_data[31:0], 32'd31);
    chk("fill.r1", rd_data[63:32], 32'd1);
    rd_en = '0;

    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hFFFFFFFF;
    step();
    clr_req = 1'b0; wr_en = 1'b0;
    chk("clr.busy_start", {31'd0, clr_busy}, 32'd1);
    chk("clr.done_start", {31'd0, clr_done}, 32'd0);
    chk("clr.nz_busy", {31'd0, nz_busy}, 32'd1);
    busy_cnt = 1; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 40; i++) begin
      wr_en   = (i == 20);
      wr_addr = 5'd2;
      wr_data = 32'hABCDABCD;
      clr_req = (i == 10) || (i == 33);
      step();
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_at = i;
      end
    end
    idle_inputs();
    chk("clr.busy_cycles", busy_cnt, 33);
    chk("clr.done_count", done_cnt, 1);
    chk("clr.done_edge", done_at, 32);
    for (int a = 0; a < 32; a++) begin
      rd_en = 4'b1111;
      rd_addr = {5'(a), 5'(a), 5'(a), 5'(a)};
      step();
      chk($sformatf("clr.r%0d.p0", a), rd_data[31:0], 32'h0);
      chk($sformatf("clr.r%0d.p3", a), rd_data[127:96], 32'h0);
    end
    rd_en = '0;

    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hA5A5A5A5;
    step();
    wr_en = 1'b0;
    rd_en = 4'b0001; rd_addr = {15'd0, 5'd20};
    step();
    chk("rstclr.r20_pre", rd_data[31:0], 32'hA5A5A5A5);
    rd_en = '0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("rstclr.busy_mid", {31'd0, clr_busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstclr.busy_in_reset", {31'd0, clr_busy}, 32'd0);
    chk("rstclr.done_in_reset", {31'd0, clr_done}, 32'd0);
    chk("rstclr.p0_in_reset", rd_data[31:0], 32'h0);
    step();
    step();
    reset = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
    end
    chk("rstclr.busy_after", busy_cnt, 0);
    chk("rstclr.done_after", done_cnt, 0);
    rd_en = 4'b1111; rd_addr = {5'd31, 5'd3, 5'd5, 5'd20};
    step();
    chk("rstclr.r20", rd_data[31:0], 32'h0);
    chk("rstclr.r5", rd_data[63:32], 32'h0);
    chk("rstclr.r3", rd_data[95:64], 32'h0);
    chk("rstclr.r31", rd_data[127:96], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
